tap_ir_dr_ctrl: RTL and testbench
=================================

Name: tap_ir_dr_ctrl

Overview:
Instruction/data-register stage directly downstream of the half TAP controller (TAP_half_route).
- Consumes the 4-bit TAP state code the controller drives on its state_obs pads, plus TDI.
- Holds a 4-bit instruction register and three data registers: BYPASS, IDCODE and an 8-bit USER register.
- Drives TDO and a USER update output.

Parameters:
- IR_W, 4, instruction register width.
- IDCODE_VAL, 32'h1A2B3C4D, IDCODE capture value; bit 0 must be 1.
- USER_W, 8, USER data register width.
- USER_RST, 8'h00, USER register reset value.

Ports:
- GCLK_Pad  in  1  clock; all state updates on the rising edge.
- TRST_Pad  in  1  asynchronous, active-low reset.
- state_obs  in  4  TAP state code from the controller, IEEE 1149.1 encoding.
- TDI_Pad  in  1  serial data in.
- TDO_Pad  out  1  serial data out.
- ir_q  out  IR_W  active instruction.
- user_q  out  USER_W  USER register parallel output.
- user_upd  out  1  one-cycle pulse when user_q is written.
- shift_act  out  1  high in Shift-DR or Shift-IR.

Behaviour:
- State codes used:
  - TLR=F, RTI=C
  - CapDR=6, ShDR=2, UpdDR=5
  - CapIR=E, ShIR=A, UpdIR=D
  - All other codes: hold all registers.
- Reset (TRST_Pad=0, asynchronous) sets:
  - ir_q=4'b0001 (IDCODE), ir_sr=0
  - byp=0, id_sr=0
  - user_sr=USER_RST, user_q=USER_RST
  - user_upd=0
- Instruction decode:
  - 4'b0001 = IDCODE
  - 4'b0010 = USER
  - 4'b1111 and every other value = BYPASS
- Rising-edge actions, keyed on the sampled state_obs:
  - TLR: ir_q<=0001 (synchronous re-init); data registers hold.
  - CapIR: ir_sr<=4'b0001.
  - ShIR: ir_sr<={TDI_Pad, ir_sr[IR_W-1:1]}.
  - UpdIR: ir_q<=ir_sr.
  - CapDR, selected by ir_q: BYPASS byp<=0; IDCODE id_sr<=IDCODE_VAL; USER user_sr<=user_q.
  - ShDR, selected register only: BYPASS byp<=TDI_Pad; IDCODE id_sr<={TDI_Pad, id_sr[31:1]}; USER user_sr<={TDI_Pad, user_sr[USER_W-1:1]}.
  - UpdDR with USER selected: user_q<=user_sr, and user_upd is 1 for exactly the following cycle.
  - UpdDR with any other instruction: no register change, user_upd stays 0.
- Unselected data registers never shift or capture.
- TDO_Pad and shift_act (combinational from state_obs and registers):
  - In ShIR: TDO_Pad=ir_sr[0].
  - In ShDR: TDO_Pad=LSB of the selected register (byp, id_sr[0] or user_sr[0]).
  - Otherwise TDO_Pad=0.
  - shift_act=(state_obs==ShDR)||(state_obs==ShIR).
- Latency:
  - ir_q changes one edge after UpdIR is sampled.
  - user_q changes one edge after UpdDR is sampled; user_upd is high in the same cycle.
- Boundary conditions:
  - N shift cycles with N≠width: the register keeps the last width bits shifted in; the oldest bits fall off bit 0.
  - ir_q changing via TLR mid-DR-scan: the selection changes immediately; partially shifted contents of the old register are retained but unused.
  - Reset mid-scan: all registers reset immediately; operation resumes from the state_obs code present after reset release.
  - Unknown or unused state codes: no action.

Test Plan:
- Reset then IDCODE read: TRST_Pad=0→1; state CapDR, 32×ShDR, UpdDR → TDO_Pad sequence LSB-first reads 32'h1A2B3C4D; ir_q=0001 throughout.
- IR load: CapIR, 4×ShIR with TDI 0,1,0,0 (LSB first), UpdIR → TDO_Pad outputs 1,0,0,0 during shift; ir_q=4'b0010 after one edge.
- USER write/read:
  - ir_q=0010; CapDR, 8×ShDR with TDI=8'hA5 LSB-first, UpdDR → user_q=8'hA5, user_upd high exactly one cycle.
  - Second scan shifting 8'h00 → TDO_Pad emits 8'hA5 LSB-first.
- BYPASS: load ir 4'b0111 (undefined); CapDR, 5×ShDR with TDI 1,1,0,1,0 → TDO_Pad 0,1,1,0,1 (one-cycle delay, captured 0 first); user_q unchanged.
- TLR re-init: ir_q=0010, state TLR for 1 cycle → ir_q=0001; user_q unchanged.
- Async reset mid-USER-shift: after 3 ShDR, TRST_Pad=0 between edges → ir_q=0001, user_q=USER_RST, user_upd=0 immediately, without a clock edge.

Source files
------------

// File: rtl/tap_ir_dr_ctrl_if.sv
// Pad-side bundle between the half TAP controller and the IR/DR stage.
// The controller (master) drives the state code and TDI; the IR/DR stage (slave) drives the rest.
interface tap_ir_dr_ctrl_if #(
  parameter int IR_W   = 4,
  parameter int USER_W = 8
);
  logic [3:0]        state_obs;
  logic              TDI_Pad;
  logic              TDO_Pad;
  logic [IR_W-1:0]   ir_q;
  logic [USER_W-1:0] user_q;
  logic              user_upd;
  logic              shift_act;

  modport master (
    output state_obs, TDI_Pad,
    input  TDO_Pad, ir_q, user_q, user_upd, shift_act
  );

  modport slave (
    input  state_obs, TDI_Pad,
    output TDO_Pad, ir_q, user_q, user_upd, shift_act
  );
endinterface

// File: rtl/tap_ir_dr_ctrl.sv
// Instruction register plus BYPASS / IDCODE / USER data registers, sequenced by the
// 1149.1 state code observed from the upstream TAP controller.
//
// code | meaning
// F    | Test-Logic-Reset: re-select IDCODE
// C    | Run-Test/Idle: hold
// 6    | Capture-DR
// 2    | Shift-DR
// 5    | Update-DR
// E    | Capture-IR
// A    | Shift-IR
// D    | Update-IR
// else | hold
module tap_ir_dr_ctrl #(
  parameter int                IR_W       = 4,
  parameter logic [31:0]       IDCODE_VAL = 32'h1A2B3C4D,
  parameter int                USER_W     = 8,
  parameter logic [USER_W-1:0] USER_RST   = '0
) (
  input logic GCLK_Pad,
  input logic TRST_Pad,
  tap_ir_dr_ctrl_if.slave tap
);

  localparam logic [3:0] ST_TLR   = 4'hF;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_UPDDR = 4'h5;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_UPDIR = 4'hD;

  localparam logic [IR_W-1:0] INS_IDCODE = IR_W'(1);
  localparam logic [IR_W-1:0] INS_USER   = IR_W'(2);

  logic [IR_W-1:0]   r_ir_sr;
  logic [IR_W-1:0]   r_ir_q;
  logic              r_byp;
  logic [31:0]       r_id_sr;
  logic [USER_W-1:0] r_user_sr;
  logic [USER_W-1:0] r_user_q;
  logic              r_user_upd;

  logic w_sel_id;
  logic w_sel_user;
  logic w_tdo;

  // Anything not explicitly decoded falls through to BYPASS.
  assign w_sel_id   = (r_ir_q == INS_IDCODE);
  assign w_sel_user = (r_ir_q == INS_USER);

  always_ff @(posedge GCLK_Pad or negedge TRST_Pad) begin
    if (!TRST_Pad) begin
      r_ir_sr    <= '0;
      r_ir_q     <= INS_IDCODE;
      r_byp      <= 1'b0;
      r_id_sr    <= '0;
      r_user_sr  <= USER_RST;
      r_user_q   <= USER_RST;
      r_user_upd <= 1'b0;
    end else begin
      r_user_upd <= 1'b0;
      case (tap.state_obs)
        ST_TLR:   r_ir_q  <= INS_IDCODE;
        ST_CAPIR: r_ir_sr <= INS_IDCODE;
        ST_SHIR:  r_ir_sr <= {tap.TDI_Pad, r_ir_sr[IR_W-1:1]};
        ST_UPDIR: r_ir_q  <= r_ir_sr;
        ST_CAPDR: begin
          if (w_sel_id)        r_id_sr   <= IDCODE_VAL;
          else if (w_sel_user) r_user_sr <= r_user_q;
          else                 r_byp     <= 1'b0;
        end
        ST_SHDR: begin
          if (w_sel_id)        r_id_sr   <= {tap.TDI_Pad, r_id_sr[31:1]};
          else if (w_sel_user) r_user_sr <= {tap.TDI_Pad, r_user_sr[USER_W-1:1]};
          else                 r_byp     <= tap.TDI_Pad;
        end
        ST_UPDDR: begin
          if (w_sel_user) begin
            r_user_q   <= r_user_sr;
            r_user_upd <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_tdo = 1'b0;
    if (tap.state_obs == ST_SHIR) begin
      w_tdo = r_ir_sr[0];
    end else if (tap.state_obs == ST_SHDR) begin
      if (w_sel_id)        w_tdo = r_id_sr[0];
      else if (w_sel_user) w_tdo = r_user_sr[0];
      else                 w_tdo = r_byp;
    end
  end

  assign tap.TDO_Pad   = w_tdo;
  assign tap.shift_act = (tap.state_obs == ST_SHDR) || (tap.state_obs == ST_SHIR);
  assign tap.ir_q      = r_ir_q;
  assign tap.user_q    = r_user_q;
  assign tap.user_upd  = r_user_upd;

endmodule

// File: tb/tb_tap_ir_dr_ctrl.sv
// Directed scans from the test plan followed by random state/TDI traffic, all checked
// against a bit-level reference model of the IR/DR stage held in the bench.
module tb_tap_ir_dr_ctrl;
  localparam logic [31:0] IDV = 32'h1A2B3C4D;

  logic GCLK_Pad = 1'b0;
  logic TRST_Pad;
  int   n_cmp = 0;
  int   n_mis = 0;

  tap_ir_dr_ctrl_if #(.IR_W(4), .USER_W(8)) tap ();

  tap_ir_dr_ctrl #(
    .IR_W(4), .IDCODE_VAL(IDV), .USER_W(8), .USER_RST(8'h00)
  ) dut (
    .GCLK_Pad (GCLK_Pad),
    .TRST_Pad (TRST_Pad),
    .tap      (tap)
  );

  always #5 GCLK_Pad = ~GCLK_Pad;

  // reference model state
  logic [3:0]  m_ir, m_irsr;
  logic        m_byp;
  logic [31:0] m_id;
  logic [7:0]  m_usr, m_uq;
  logic        m_upd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ir = 4'd1; m_irsr = 4'd0; m_byp = 1'b0; m_id = 32'd0;
    m_usr = 8'h00; m_uq = 8'h00; m_upd = 1'b0;
  endtask

  function automatic int sel();  // 0 bypass, 1 idcode, 2 user
    if (m_ir == 4'd1) return 1;
    if (m_ir == 4'd2) return 2;
    return 0;
  endfunction

  function automatic logic model_tdo(input logic [3:0] st);
    if (st == 4'hA) return m_irsr[0];
    if (st == 4'h2) begin
      case (sel())
        1:       return m_id[0];
        2:       return m_usr[0];
        default: return m_byp;
      endcase
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input logic [3:0] st, input logic tdi);
    m_upd = 1'b0;
    case (st)
      4'hF: m_ir = 4'd1;
      4'hE: m_irsr = 4'd1;
      4'hA: m_irsr = (m_irsr >> 1) | ({3'b000, tdi} << 3);
      4'hD: m_ir = m_irsr;
      4'h6: case (sel())
              1: m_id = IDV;
              2: m_usr = m_uq;
              default: m_byp = 1'b0;
            endcase
      4'h2: case (sel())
              1: m_id = (m_id >> 1) | ({31'd0, tdi} << 31);
              2: m_usr = (m_usr >> 1) | ({7'd0, tdi} << 7);
              default: m_byp = tdi;
            endcase
      4'h5: if (sel() == 2) begin m_uq = m_usr; m_upd = 1'b1; end
      default: ;
    endcase
  endtask

  // Called just after a falling edge; returns the TDO value seen in this cycle.
  task automatic step(input logic [3:0] st, input logic tdi, output logic tdo);
    tap.state_obs = st;
    tap.TDI_Pad   = tdi;
    #1;
    chk("tdo", 32'(tap.TDO_Pad), 32'(model_tdo(st)));
    chk("shift_act", 32'(tap.shift_act), 32'((st == 4'h2) || (st == 4'hA)));
    tdo = tap.TDO_Pad;
    @(posedge GCLK_Pad);
    model_edge(st, tdi);
    #1;
    chk("ir_q", 32'(tap.ir_q), 32'(m_ir));
    chk("user_q", 32'(tap.user_q), 32'(m_uq));
    chk("user_upd", 32'(tap.user_upd), 32'(m_upd));
    @(negedge GCLK_Pad);
  endtask

  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic b;
    dout = '0;
    step(4'h6, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      step(4'h2, din[i], b);
      dout[i] = b;
    end
    step(4'h5, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [3:0] din, output logic [3:0] dout);
    logic b;
    dout = '0;
    step(4'hE, 1'b0, b);
    for (int i = 0; i < 4; i++) begin
      step(4'hA, din[i], b);
      dout[i] = b;
    end
    step(4'hD, 1'b0, b);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  di;
    logic        b;

    TRST_Pad      = 1'b0;
    tap.state_obs = 4'hC;
    tap.TDI_Pad   = 1'b0;
    model_reset();
    @(negedge GCLK_Pad);
    #1;
    chk("rst_ir_q", 32'(tap.ir_q), 32'h1);
    chk("rst_user_q", 32'(tap.user_q), 32'h0);
    chk("rst_user_upd", 32'(tap.user_upd), 32'h0);
    chk("rst_tdo", 32'(tap.TDO_Pad), 32'h0);
    @(negedge GCLK_Pad);
    TRST_Pad = 1'b1;
    step(4'hC, 1'b0, b);

    // IDCODE read
    scan_dr(32'h0, 32, d);
    chk("idcode_read", d, IDV);
    chk("idcode_ir", 32'(tap.ir_q), 32'h1);

    // IR load to USER
    scan_ir(4'b0010, di);
    chk("ir_shift_out", 32'(di), 32'h1);
    chk("ir_loaded", 32'(tap.ir_q), 32'h2);

    // USER write then readback
    scan_dr(32'hA5, 8, d);
    chk("user_write", 32'(tap.user_q), 32'hA5);
    chk("user_upd_hi", 32'(tap.user_upd), 32'h1);
    step(4'hC, 1'b0, b);
    chk("user_upd_lo", 32'(tap.user_upd), 32'h0);
    scan_dr(32'h0, 8, d);
    chk("user_read", d & 32'hFF, 32'hA5);
    chk("user_after_zero", 32'(tap.user_q), 32'h00);
    scan_dr(32'h3C, 8, d);
    // Short scan: 5 bits keep the older 3 bits in the top-down order
    scan_dr(32'h1F, 5, d);
    chk("user_short_scan", 32'(tap.user_q), 32'hF9);

    // BYPASS via undefined instruction
    scan_ir(4'b0111, di);
    chk("byp_ir", 32'(tap.ir_q), 32'h7);
    scan_dr(32'b01011, 5, d);
    chk("bypass_seq", d & 32'h1F, 32'b10110);
    chk("bypass_user_hold", 32'(tap.user_q), 32'hF9);

    // TLR re-init from USER
    scan_ir(4'b0010, di);
    step(4'hF, 1'b0, b);
    chk("tlr_ir", 32'(tap.ir_q), 32'h1);
    chk("tlr_user_hold", 32'(tap.user_q), 32'hF9);

    // Async reset mid USER shift
    scan_ir(4'b0010, di);
    scan_dr(32'h5A, 8, d);
    step(4'h6, 1'b0, b);
    for (int i = 0; i < 3; i++) step(4'h2, 1'b1, b);
    tap.state_obs = 4'h2;
    TRST_Pad = 1'b0;
    model_reset();
    #1;
    chk("arst_ir_q", 32'(tap.ir_q), 32'h1);
    chk("arst_user_q", 32'(tap.user_q), 32'h00);
    chk("arst_user_upd", 32'(tap.user_upd), 32'h0);
    @(negedge GCLK_Pad);
    TRST_Pad = 1'b1;

    // Random traffic, biased toward scan codes
    for (int i = 0; i < 800; i++) begin
      logic [3:0] st;
      case ($urandom_range(0, 9))
        0: st = 4'($urandom_range(0, 15));
        1: st = 4'hE;
        2: st = 4'hD;
        3: st = 4'h6;
        4: st = 4'h5;
        5: st = 4'hA;
        6: st = ($urandom_range(0, 7) == 0) ? 4'hF : 4'hC;
        default: st = 4'h2;
      endcase
      step(st, 1'($urandom_range(0, 1)), b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
